// File: rtl/bomber_pkg.sv
// Shared definitions for the Bomberman display pipe: frame-update FSM
// encoding, direction key bit positions and default visible area.
package bomber_pkg;

    // Vertical-blanking update sequencer states.
    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,  // active video, positions frozen
        S_UPDATE = 2'd1,  // walking the players, one per cycle
        S_DONE   = 2'd2   // blanking work finished, waiting for SOF
    } state_t;

    // Bit positions inside one player's 4-bit key nibble (active-low).
    localparam int KEY_RIGHT = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_LEFT  = 3;

    // Default visible area.
    localparam int HACTIVE_DEF = 800;
    localparam int VACTIVE_DEF = 600;

    // Width of a player index; a single player still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis position step: increment or decrement by STEP and clamp the
// result into [0, MAX]. Purely combinational; shared by all players.
module axis_step #(
    parameter int COORD_W = 11,
    parameter int STEP    = 2,
    parameter int MAX     = 768
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               inc,
    input  logic               dec,
    output logic [COORD_W-1:0] nxt
);

    // One extra bit so pos+STEP can never wrap before the clamp.
    localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] MAX_W  = (COORD_W+1)'(MAX);

    logic [COORD_W:0] pos_w;
    logic [COORD_W:0] sum_w;
    logic [COORD_W:0] res_w;

    // Opposing keys cancel; an out-of-range start position is pulled back to MAX
    // even when the player does not press anything.
    always_comb begin
        pos_w = {1'b0, pos};
        sum_w = pos_w + STEP_W;
        res_w = pos_w;
        if (inc && !dec) begin
            res_w = (sum_w > MAX_W) ? MAX_W : sum_w;
        end else if (dec && !inc) begin
            res_w = (pos_w < STEP_W) ? '0 : (pos_w - STEP_W);
        end
        if (res_w > MAX_W) begin
            res_w = MAX_W;
        end
        nxt = res_w[COORD_W-1:0];
    end

endmodule

// File: rtl/multi_player_mover.sv
// Per-frame sprite position controller for several players. Key inputs are
// synchronised, and during vertical blanking (EOF..SOF) every FRAME_DIV-th
// frame each enabled player is moved by STEP pixels, one player per clock.
// Positions never change during active video.
module multi_player_mover
    import bomber_pkg::*;
#(
    parameter int NPLAYERS  = 2,
    parameter int COORD_W   = 11,
    parameter int HACTIVE   = HACTIVE_DEF,
    parameter int VACTIVE   = VACTIVE_DEF,
    parameter int SPRITE    = 32,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter logic [NPLAYERS*COORD_W-1:0] START_X = {11'd736, 11'd32},
    parameter logic [NPLAYERS*COORD_W-1:0] START_Y = {11'd536, 11'd32}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          SOF,
    input  logic                          EOF,
    input  logic [4*NPLAYERS-1:0]         key,
    input  logic [NPLAYERS-1:0]           enable,
    output logic [NPLAYERS*COORD_W-1:0]   pos_x,
    output logic [NPLAYERS*COORD_W-1:0]   pos_y,
    output logic [NPLAYERS-1:0]           moved,
    output logic                          update_done,
    output logic                          overrun,
    output logic [1:0]                    fsm_state
);

    localparam int              IDX_W    = idx_width(NPLAYERS);
    localparam int              MAX_X    = HACTIVE - SPRITE;
    localparam int              MAX_Y    = VACTIVE - SPRITE;
    localparam logic [7:0]      DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPLAYERS - 1);

    // Key synchroniser stages; all ones means nothing pressed.
    logic [4*NPLAYERS-1:0] key_meta;
    logic [4*NPLAYERS-1:0] key_sync;

    // Sequencer state.
    state_t           state;
    logic [7:0]       div;
    logic [IDX_W-1:0] idx;

    // Per-player position registers.
    logic [COORD_W-1:0] px [NPLAYERS];
    logic [COORD_W-1:0] py [NPLAYERS];

    // Currently selected player.
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [3:0]         cur_key;
    logic               cur_en;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic               upd_fire;

    assign fsm_state = state;

    // Two-flop synchroniser for the asynchronous push buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Select the position, keys and enable of the player being updated.
    always_comb begin
        cur_x   = '0;
        cur_y   = '0;
        cur_key = 4'hF;
        cur_en  = 1'b0;
        for (int i = 0; i < NPLAYERS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_x   = px[i];
                cur_y   = py[i];
                cur_key = key_sync[4*i +: 4];
                cur_en  = enable[i];
            end
        end
    end

    axis_step #(
        .COORD_W (COORD_W),
        .STEP    (STEP),
        .MAX     (MAX_X)
    ) u_step_x (
        .pos (cur_x),
        .inc (~cur_key[KEY_RIGHT]),
        .dec (~cur_key[KEY_LEFT]),
        .nxt (nx)
    );

    axis_step #(
        .COORD_W (COORD_W),
        .STEP    (STEP),
        .MAX     (MAX_Y)
    ) u_step_y (
        .pos (cur_y),
        .inc (~cur_key[KEY_DOWN]),
        .dec (~cur_key[KEY_UP]),
        .nxt (ny)
    );

    // A player is written only in S_UPDATE, when enabled and not aborted by SOF.
    assign upd_fire = (state == S_UPDATE) && !SOF && cur_en;

    // Blanking sequencer: frame divider, player walk, abort on late SOF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_ACTIVE;
            div         <= '0;
            idx         <= '0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            update_done <= 1'b0;
            case (state)
                S_ACTIVE: begin
                    // SOF wins over a coincident EOF, so EOF only counts alone.
                    if (EOF && !SOF) begin
                        if (div == DIV_LAST) begin
                            div   <= '0;
                            idx   <= '0;
                            state <= S_UPDATE;
                        end else begin
                            div   <= div + 8'd1;
                            state <= S_DONE;
                        end
                    end
                end
                S_UPDATE: begin
                    if (SOF) begin
                        overrun <= 1'b1;
                        state   <= S_ACTIVE;
                    end else if (idx == IDX_LAST) begin
                        update_done <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (SOF) begin
                        state <= S_ACTIVE;
                    end
                end
                default: begin
                    state <= S_ACTIVE;
                end
            endcase
        end
    end

    // Position datapath: write back the stepped coordinates and flag real changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPLAYERS; i++) begin
                px[i] <= START_X[i*COORD_W +: COORD_W];
                py[i] <= START_Y[i*COORD_W +: COORD_W];
            end
            moved <= '0;
        end else begin
            moved <= '0;
            if (upd_fire) begin
                px[idx]    <= nx;
                py[idx]    <= ny;
                moved[idx] <= (nx != cur_x) || (ny != cur_y);
            end
        end
    end

    // Flatten per-player registers onto the packed output buses.
    always_comb begin
        pos_x = '0;
        pos_y = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            pos_x[i*COORD_W +: COORD_W] = px[i];
            pos_y[i*COORD_W +: COORD_W] = py[i];
        end
    end

endmodule

// File: tb/tb_multi_player_mover.sv
// Bench for multi_player_mover: two instances (default area/FRAME_DIV=1, and a
// 768x568 area with FRAME_DIV=3 and edge/out-of-range start positions) share
// the frame pulses. A reference model predicts each blanking's outcome.
module tb_multi_player_mover;

    localparam int CW = 11;
    localparam int W  = 4 * CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sof;
    logic        eof;
    logic [7:0]  key_a, key_b;
    logic [1:0]  en_a, en_b;

    logic [2*CW-1:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;
    logic [1:0]      moved_a, moved_b;
    logic            done_a, done_b, ovr_a, ovr_b;
    logic [1:0]      st_a, st_b;

    multi_player_mover u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .SOF         (sof),
        .EOF         (eof),
        .key         (key_a),
        .enable      (en_a),
        .pos_x       (pos_x_a),
        .pos_y       (pos_y_a),
        .moved       (moved_a),
        .update_done (done_a),
        .overrun     (ovr_a),
        .fsm_state   (st_a)
    );

    multi_player_mover #(
        .HACTIVE   (768),
        .VACTIVE   (568),
        .FRAME_DIV (3),
        .START_X   ({11'd736, 11'd1}),
        .START_Y   ({11'd590, 11'd32})
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .SOF         (sof),
        .EOF         (eof),
        .key         (key_b),
        .enable      (en_b),
        .pos_x       (pos_x_b),
        .pos_y       (pos_y_b),
        .moved       (moved_b),
        .update_done (done_b),
        .overrun     (ovr_b),
        .fsm_state   (st_b)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    int   mx [2][2];
    int   my [2][2];
    int   mdiv [2];
    logic movr [2];

    int mv_cnt [2][2];
    int done_cnt [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int fdiv(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int max_x(input int d);
        return (d == 0) ? 768 : 736;
    endfunction
    function automatic int max_y(input int d);
        return (d == 0) ? 568 : 536;
    endfunction

    function automatic int ref_axis(input int pos, input bit plus, input bit minus, input int maxv);
        int v;
        v = pos;
        if (plus && !minus) v = pos + 2;
        else if (minus && !plus) v = pos - 2;
        if (v < 0) v = 0;
        if (v > maxv) v = maxv;
        return v;
    endfunction

    function automatic logic [W-1:0] pack_model(input int d);
        return {CW'(my[d][1]), CW'(my[d][0]), CW'(mx[d][1]), CW'(mx[d][0])};
    endfunction

    // Predict one blanking; limit = number of players reached before SOF.
    task automatic model_blank(input int d, input logic [7:0] k, input logic [1:0] en,
                               input int limit, output logic [1:0] mask, output int ndone);
        int nx, ny;
        mask  = 2'b00;
        ndone = 0;
        if (mdiv[d] == fdiv(d) - 1) begin
            mdiv[d] = 0;
            for (int p = 0; p < 2; p++) begin
                if (p < limit && en[p]) begin
                    nx = ref_axis(mx[d][p], !k[4*p+0], !k[4*p+3], max_x(d));
                    ny = ref_axis(my[d][p], !k[4*p+1], !k[4*p+2], max_y(d));
                    if (nx != mx[d][p] || ny != my[d][p]) mask[p] = 1'b1;
                    mx[d][p] = nx;
                    my[d][p] = ny;
                end
            end
            if (limit >= 2) ndone = 1;
            else movr[d] = 1'b1;
        end else begin
            mdiv[d] = mdiv[d] + 1;
        end
    endtask

    task automatic model_reset();
        mx[0][0] = 32;  mx[0][1] = 736; my[0][0] = 32; my[0][1] = 536;
        mx[1][0] = 1;   mx[1][1] = 736; my[1][0] = 32; my[1][1] = 590;
        for (int d = 0; d < 2; d++) begin
            mdiv[d] = 0;
            movr[d] = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (moved_a[p] === 1'b1) mv_cnt[0][p] <= mv_cnt[0][p] + 1;
            if (moved_b[p] === 1'b1) mv_cnt[1][p] <= mv_cnt[1][p] + 1;
        end
        if (done_a === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
        if (done_b === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
    end

    // ---------------- driver ----------------
    // mode 0: normal blanking, 1: SOF one idle cycle after EOF, 2: SOF+EOF together.
    task automatic run_frame(input int mode);
        logic [1:0]   mask_a, mask_b;
        int           nd_a, nd_b;
        int           mv0 [2][2];
        int           d0 [2];
        logic [W-1:0] e_a, e_b;
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            d0[d] = done_cnt[d];
            for (int p = 0; p < 2; p++) mv0[d][p] = mv_cnt[d][p];
        end
        mask_a = 2'b00; mask_b = 2'b00; nd_a = 0; nd_b = 0;
        if (mode == 2) begin
            sof = 1'b1; eof = 1'b1;
            @(negedge clk);
            sof = 1'b0; eof = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            model_blank(0, key_a, en_a, (mode == 1) ? 1 : 2, mask_a, nd_a);
            model_blank(1, key_b, en_b, (mode == 1) ? 1 : 2, mask_b, nd_b);
            eof = 1'b1;
            @(negedge clk);
            eof = 1'b0;
            if (mode == 1) @(negedge clk);
            else repeat (4) @(negedge clk);
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
        end
        exp_q.push_back(pack_model(0));
        exp_q.push_back(pack_model(1));
        @(negedge clk);
        e_a = exp_q.pop_front();
        e_b = exp_q.pop_front();
        check_val("pos_a", {pos_y_a, pos_x_a}, e_a);
        check_val("pos_b", {pos_y_b, pos_x_b}, e_b);
        for (int p = 0; p < 2; p++) begin
            check_val($sformatf("moved_a%0d", p), 64'(mv_cnt[0][p] - mv0[0][p]), 64'(mask_a[p]));
            check_val($sformatf("moved_b%0d", p), 64'(mv_cnt[1][p] - mv0[1][p]), 64'(mask_b[p]));
        end
        check_val("done_a", 64'(done_cnt[0] - d0[0]), 64'(nd_a));
        check_val("done_b", 64'(done_cnt[1] - d0[1]), 64'(nd_b));
        repeat (3) @(negedge clk);
        check_val("hold_a", {pos_y_a, pos_x_a}, e_a);
        check_val("hold_b", {pos_y_b, pos_x_b}, e_b);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence ----------------
    initial begin
        int x0, y0, db;
        reset = 1'b1; sof = 1'b0; eof = 1'b0;
        key_a = 8'hFF; key_b = 8'hFF; en_a = 2'b11; en_b = 2'b11;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_pos_a", {pos_y_a, pos_x_a}, {11'd536, 11'd32, 11'd736, 11'd32});
        check_val("rst_pos_b", {pos_y_b, pos_x_b}, {11'd590, 11'd32, 11'd736, 11'd1});
        check_val("rst_moved", {moved_b, moved_a}, 0);
        check_val("rst_done", {done_b, done_a}, 0);
        check_val("rst_ovr", {ovr_b, ovr_a}, 0);
        check_val("rst_state", {st_b, st_a}, 0);
        reset = 1'b0;

        // Idle frames; B clamps its out-of-range start y on its first update.
        repeat (3) run_frame(0);
        check_val("b_clamp_y", pos_y_b[2*CW-1:CW], 536);

        // P0 of A moves right for five frames.
        key_a = 8'hFE;
        repeat (5) run_frame(0);
        check_val("a_p0_x42", pos_x_a[CW-1:0], 42);
        check_val("a_p0_y32", pos_y_a[CW-1:0], 32);

        // B: P1 pinned at right edge, P0 walks left from x=1; six frames at FRAME_DIV=3.
        key_a = 8'hFF;
        key_b = 8'hE7;
        db = done_cnt[1];
        repeat (6) run_frame(0);
        check_val("b_two_updates", 64'(done_cnt[1] - db), 2);
        check_val("b_p0_x0", pos_x_b[CW-1:0], 0);
        check_val("b_p1_x736", pos_x_b[2*CW-1:CW], 736);

        // Opposing keys cancel, then a diagonal step.
        key_b = 8'hFF;
        key_a = 8'hF6;
        run_frame(0);
        key_a = 8'hF9;
        run_frame(0);
        x0 = mx[0][0];
        y0 = my[0][0];
        key_a = 8'hFC;
        run_frame(0);
        check_val("diag_x", pos_x_a[CW-1:0], 64'(x0 + 2));
        check_val("diag_y", pos_y_a[CW-1:0], 64'(y0 + 2));

        // P0 disabled while P1 moves left.
        en_a  = 2'b10;
        key_a = 8'h7E;
        repeat (2) run_frame(0);
        check_val("frozen_p0_x", pos_x_a[CW-1:0], 64'(x0 + 2));
        check_val("p1_left_x", pos_x_a[2*CW-1:CW], 732);
        en_a = 2'b11;

        // Late SOF aborts after P0; then SOF+EOF together; then a clean frame.
        key_a = 8'hEE;
        key_b = 8'hEE;
        run_frame(1);
        check_val("ovr_a", ovr_a, movr[0]);
        check_val("ovr_b", ovr_b, movr[1]);
        check_val("ovr_a_set", ovr_a, 1);
        run_frame(2);
        run_frame(0);
        check_val("ovr_sticky", ovr_a, 1);

        // Reset in the middle of an update sequence.
        repeat (4) @(negedge clk);
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        check_val("state_upd", st_a, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid_rst_pos_a", {pos_y_a, pos_x_a}, {11'd536, 11'd32, 11'd736, 11'd32});
        check_val("mid_rst_pos_b", {pos_y_b, pos_x_b}, {11'd590, 11'd32, 11'd736, 11'd1});
        check_val("mid_rst_ovr", {ovr_b, ovr_a}, 0);
        check_val("mid_rst_state", st_a, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        key_a = 8'hFF;
        key_b = 8'hFF;
        run_frame(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
